hazard_stall_ctrl: RTL

- Pipeline hazard and stall sequencer for the 5-stage CPU.
- Decides each cycle whether the ID-stage control word passes to ID/EX or is replaced by the all-zero bubble. Drives the control-select mux (hd_o), PC / IF-ID write enables and the IF-ID flush.
- Freezes the whole pipeline while a multi-cycle data-memory access is outstanding, with a timeout to a sticky error state.

---
 rtl/hazard_stall_ctrl.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/hazard_stall_ctrl.sv
// Hazard/stall sequencer for the 5-stage pipeline: load-use bubbles, branch flush,
// data-memory freeze with timeout. Optional perf counters under HAZARD_STALL_PERF_CNT_EN.
module hazard_stall_ctrl #(
   parameter int REG_AW      = 5,
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [REG_AW-1:0] id_rs_i,
   input  logic [REG_AW-1:0] id_rt_i,
   input  logic              id_uses_rt_i,
   input  logic              idex_memread_i,
   input  logic [REG_AW-1:0] idex_rt_i,
   input  logic              exmem_memreq_i,
   input  logic              dmem_ack_i,
   input  logic              branch_taken_i,
   output logic              hd_o,
   output logic              pc_write_o,
   output logic              ifid_write_o,
   output logic              ifid_flush_o,
   output logic              pipe_stall_o,
   output logic              err_o,
   output logic [CNT_W-1:0]  bubble_cnt_o,
   output logic [CNT_W-1:0]  memwait_cnt_o
);

   typedef enum logic [1:0] {
      ST_RUN,
      ST_MEM_WAIT,
      ST_ERROR
   } state_t;

   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(MEM_TIMEOUT);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic             lu, mm, run_eval;

   assign lu = idex_memread_i && (idex_rt_i != '0) &&
               ((idex_rt_i == id_rs_i) || (id_uses_rt_i && (idex_rt_i == id_rt_i)));
   assign mm = exmem_memreq_i && !dmem_ack_i;

   // NOTE: every output and next-state variable gets a default first, so no path
   // through the case can leave one unassigned and infer a latch.
   always_comb begin
      state_d      = state_q;
      wait_cnt_d   = wait_cnt_q;
      run_eval     = 1'b0;
      hd_o         = 1'b0;
      pc_write_o   = 1'b1;
      ifid_write_o = 1'b1;
      ifid_flush_o = 1'b0;
      pipe_stall_o = 1'b0;
      err_o        = 1'b0;

      case (state_q)
         ST_RUN: begin
            if (mm) begin
               pipe_stall_o = 1'b1;
               pc_write_o   = 1'b0;
               ifid_write_o = 1'b0;
               state_d      = ST_MEM_WAIT;
               wait_cnt_d   = CNT_W'(1);
            end else begin
               run_eval = 1'b1;
            end
         end
         ST_MEM_WAIT: begin
            if (dmem_ack_i) begin
               // Release cycle behaves exactly like RUN with no miss.
               run_eval   = 1'b1;
               state_d    = ST_RUN;
               wait_cnt_d = '0;
            end else begin
               pipe_stall_o = 1'b1;
               pc_write_o   = 1'b0;
               ifid_write_o = 1'b0;
               if (wait_cnt_q == TIMEOUT_C) state_d = ST_ERROR;
               else                         wait_cnt_d = wait_cnt_q + CNT_W'(1);
            end
         end
         ST_ERROR: begin
            pipe_stall_o = 1'b1;
            pc_write_o   = 1'b0;
            ifid_write_o = 1'b0;
            err_o        = 1'b1;
         end
         default: state_d = ST_RUN;
      endcase

      if (run_eval) begin
         if (lu) begin
            hd_o         = 1'b1;
            pc_write_o   = 1'b0;
            ifid_write_o = 1'b0;
         end else if (branch_taken_i) begin
            ifid_flush_o = 1'b1;
         end
      end

      // Hold the defined reset values on the outputs for as long as reset is asserted.
      if (!rst_i) begin
         hd_o         = 1'b0;
         pc_write_o   = 1'b1;
         ifid_write_o = 1'b1;
         ifid_flush_o = 1'b0;
         pipe_stall_o = 1'b0;
         err_o        = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of block ordering.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q    <= ST_RUN;
         wait_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

`ifdef HAZARD_STALL_PERF_CNT_EN
   logic [CNT_W-1:0] bubble_cnt_q, memwait_cnt_q;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         bubble_cnt_q  <= '0;
         memwait_cnt_q <= '0;
      end else begin
         if (hd_o && (bubble_cnt_q != '1))
            bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
         if ((state_q == ST_MEM_WAIT) && (memwait_cnt_q != '1))
            memwait_cnt_q <= memwait_cnt_q + CNT_W'(1);
      end
   end

   assign bubble_cnt_o  = bubble_cnt_q;
   assign memwait_cnt_o = memwait_cnt_q;
`else
   assign bubble_cnt_o  = '0;
   assign memwait_cnt_o = '0;
`endif

endmodule
